regwr_arbiter: RTL
==================

# regwr_arbiter

Round-robin write-port arbiter for the CPU's 8-entry register file. It accepts register-write requests from several datapath sources (ALU writeback, load unit, etc.) and serialises them at one per cycle onto the single write port. It drives the select (S2..S0) and enable (E) inputs of the `decoder_3_8` that generates per-register write strobes, and muxes the winning write data.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `DW`, default 16: register data width.
- `R0_ZERO`, default 1: when 1, writes to register 0 are granted but discarded (decoder enable held low).
- `clk`  in  1: clock, rising-edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `req`  in  NREQ: per-requester write request; level, held until granted.
- `req_addr`  in  3*NREQ: destination register of requester i, in bits [3i+2:3i].
- `req_data`  in  DW*NREQ: write data of requester i, in bits [DW*i+DW-1:DW*i].
- `stall`  in  1: when high, no new grant is issued this cycle.
- `gnt`  out  NREQ: registered one-hot grant pulse, one cycle wide.
- `S2`, `S1`, `S0`  out  1 each: registered register-select to `decoder_3_8`.
- `E`  out  1: registered decoder enable (write strobe qualifier).
- `wr_data`  out  DW: registered write data to the register file.
- `busy`  out  1: combinational; high when any `req` bit is unserved (req & ~gnt nonzero).

## Operation
- State: round-robin pointer `last` (index of most recently granted requester), plus the output registers. No other FSM states: each cycle is ARBITRATE (when requests are eligible) or IDLE.
- Eligible set each cycle is `req & ~gnt`. A requester whose grant pulse is currently high is masked, so it cannot be re-granted off a stale `req`.
- Arbitration: search order is `last+1, last+2, … , last` modulo NREQ. The first eligible index wins.
- On a clock edge where `stall`=0 and the eligible set is nonzero, with winner w:
  - `gnt` <= one-hot(w).
  - {S2,S1,S0} <= req_addr[w].
  - `wr_data` <= req_data[w].
  - `E` <= 1, except `E` <= 0 if R0_ZERO=1 and req_addr[w]==0.
  - `last` <= w.
- Otherwise (stall=1 or nothing eligible):
  - `gnt` <= 0 and `E` <= 0.
  - S2..S0, `wr_data` and `last` hold their values.
- Requester protocol: a requester holds `req`, `req_addr` and `req_data` stable until it sees its `gnt` bit high. It then drops `req` in that same cycle, or raises a new request the following cycle.
- Two requesters targeting the same register are both granted, in round-robin order. The later grant wins in the register file. The arbiter performs no merging.
- Reset (asynchronous, any time, including mid-grant):
  - `gnt`=0, `E`=0, S2..S0=0, `wr_data`=0.
  - `last`=NREQ-1, so requester 0 has first priority after reset.
  - A grant pulse in flight is cancelled. Its write does not occur.

## Timing
- Latency: request sampled at edge N. Grant and decoder drive are valid in the cycle after edge N, so the register file writes at edge N+1.
- Throughput: one write per cycle, sustained while eligible requests exist and `stall`=0.
- `gnt`, `E`, S2..S0 and `wr_data` change only on `clk` edges or `rst`. All four align in the same cycle.
- Stall:
  - `stall` is sampled at the edge.
  - A grant already issued (outputs valid) completes regardless of `stall`.
  - Stall only blocks the next grant.
- Worst-case wait: a continuously requesting source is granted within NREQ cycles of unstalled operation.

## Test plan
- Reset with requests pending:
  - Stimulus: rst=1 with req=4'b1111.
  - Required: gnt=0, E=0, S=3'b000, wr_data=0 throughout reset.
  - Release rst: first grant is gnt=4'b0001 on the next edge.
- Single write:
  - Stimulus: req[2]=1, addr=5, data=16'hA5A5.
  - Required: one cycle later gnt=4'b0100, {S2,S1,S0}=3'b101, E=1, wr_data=16'hA5A5.
  - Requester drops req: next cycle gnt=0, E=0, busy=0.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held, each requester re-requesting immediately after its grant.
  - Required: grant order 0,1,2,3,0,1…, one per cycle, never repeating an index twice in a row.
- R0 discard:
  - Stimulus: requester 1 writes addr=0, data=16'hFFFF with R0_ZERO=1.
  - Required: gnt=4'b0010 pulses, E stays 0.
  - With R0_ZERO=0, E=1 and S=3'b000.
- Stall:
  - Stimulus: req=4'b0011, stall=1 for 3 cycles, then 0.
  - Required: no gnt and E=0 for those 3 cycles, busy=1.
  - After release: gnt=4'b0001 then 4'b0010 on consecutive cycles.
- Reset mid-grant:
  - Stimulus: assert rst asynchronously while gnt=4'b1000 and E=1.
  - Required: E and gnt fall immediately, no register write.
  - After release with req=4'b1000: gnt=4'b1000 is re-issued.

Source files
------------

// File: rtl/regwr_arbiter_if.sv
// regwr_arbiter_if: bus between register-write requesters and the write-port
// arbiter.
//   req       - per-requester write request (level, held until granted)
//   req_addr  - destination register of requester i in bits [3i+2:3i]
//   req_data  - write data of requester i in bits [DW*i+DW-1:DW*i]
//   stall     - blocks issue of a new grant this cycle
//   gnt       - registered one-hot grant pulse
//   S2,S1,S0  - registered register select to decoder_3_8
//   E         - registered decoder enable (write strobe qualifier)
//   wr_data   - registered write data to the register file
//   busy      - any request still unserved (combinational)
interface regwr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16
);
  logic [NREQ-1:0]    req;
  logic [3*NREQ-1:0]  req_addr;
  logic [DW*NREQ-1:0] req_data;
  logic               stall;
  logic [NREQ-1:0]    gnt;
  logic               S2;
  logic               S1;
  logic               S0;
  logic               E;
  logic [DW-1:0]      wr_data;
  logic               busy;

  // Requester side: drives requests, observes grants and the write port.
  modport master (
    output req, req_addr, req_data, stall,
    input  gnt, S2, S1, S0, E, wr_data, busy
  );

  // Arbiter side.
  modport slave (
    input  req, req_addr, req_data, stall,
    output gnt, S2, S1, S0, E, wr_data, busy
  );
endinterface

// File: rtl/regwr_arbiter.sv
// regwr_arbiter: round-robin arbiter serialising register-write requests onto
// the single write port of an 8-entry register file, one write per cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - regwr_arbiter_if slave modport (requests in, grant/decoder/data out)
// Parameters: NREQ requesters (2..8), DW data width, R0_ZERO discards writes
// to register 0 by keeping the decoder enable low.
module regwr_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 16,
  parameter bit R0_ZERO = 1'b1
) (
  input logic           clk,
  input logic           rst,
  regwr_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] gnt_r;
  logic [2:0]      sel_r;
  logic            e_r;
  logic [DW-1:0]   wr_data_r;
  logic [IW-1:0]   last_r;

  logic [NREQ-1:0] elig_s;
  logic            win_found_s;
  logic [IW-1:0]   win_idx_s;
  logic [IW-1:0]   cand_s;
  logic [2:0]      win_addr_s;
  logic [DW-1:0]   win_data_s;

  logic [NREQ-1:0] gnt_nxt_s;
  logic [2:0]      sel_nxt_s;
  logic            e_nxt_s;
  logic [DW-1:0]   wr_data_nxt_s;
  logic [IW-1:0]   last_nxt_s;

  // Index k steps after the round-robin pointer, wrapping at NREQ.
  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int k);
    return IW'((int'(base) + k) % NREQ);
  endfunction

  // Round-robin search over eligible requesters, starting just after last_r.
  // A requester whose grant pulse is high is masked so a stale req cannot
  // win twice in a row.
  always_comb begin
    elig_s      = bus.req & ~gnt_r;
    win_found_s = 1'b0;
    win_idx_s   = last_r;
    cand_s      = last_r;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = rr_index(last_r, k);
      if (!win_found_s && elig_s[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
    win_addr_s = bus.req_addr[3*int'(win_idx_s) +: 3];
    win_data_s = bus.req_data[DW*int'(win_idx_s) +: DW];
  end

  // Next values of the output registers and the round-robin pointer.
  always_comb begin
    gnt_nxt_s     = '0;
    sel_nxt_s     = sel_r;
    e_nxt_s       = 1'b0;
    wr_data_nxt_s = wr_data_r;
    last_nxt_s    = last_r;
    if (!bus.stall && win_found_s) begin
      gnt_nxt_s[win_idx_s] = 1'b1;
      sel_nxt_s            = win_addr_s;
      wr_data_nxt_s        = win_data_s;
      last_nxt_s           = win_idx_s;
      if (R0_ZERO && (win_addr_s == 3'd0)) begin
        e_nxt_s = 1'b0;
      end else begin
        e_nxt_s = 1'b1;
      end
    end else begin
      gnt_nxt_s = '0;
      e_nxt_s   = 1'b0;
    end
  end

  // Output registers; reset cancels any grant in flight and points the
  // round-robin at NREQ-1 so requester 0 is served first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_r     <= '0;
      sel_r     <= 3'd0;
      e_r       <= 1'b0;
      wr_data_r <= '0;
      last_r    <= IW'(NREQ - 1);
    end else begin
      gnt_r     <= gnt_nxt_s;
      sel_r     <= sel_nxt_s;
      e_r       <= e_nxt_s;
      wr_data_r <= wr_data_nxt_s;
      last_r    <= last_nxt_s;
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.S2      = sel_r[2];
  assign bus.S1      = sel_r[1];
  assign bus.S0      = sel_r[0];
  assign bus.E       = e_r;
  assign bus.wr_data = wr_data_r;
  assign bus.busy    = |(bus.req & ~gnt_r);

endmodule
